// File: rtl/axi_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_reader_pkg
// Description : Shared types and constants for the axi_reader AXI4 read
//               master: FSM state encoding, AXI response/burst codes, the
//               4 KB page size and the packed {addr, len} request word.
//               Optional build macro used by the block:
//               AXI_READER_BOUNDARY_4K_EN (split bursts at 4 KB pages).
// Revision    : 1.0 - initial release
// ============================================================================
package axi_reader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AR    = 3'd1,
        S_R     = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam int unsigned BOUNDARY_4K    = 4096;

    // Request word as presented on read_req_data: address in the upper half.
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] len;
    } read_req_t;

endpackage : axi_reader_pkg
`default_nettype wire

// File: rtl/axi_reader_burst_calc.sv
`default_nettype none
// ============================================================================
// Module      : axi_reader_burst_calc
// Description : Combinational burst sizing. From the next burst address and
//               the number of beats still to fetch, produces the AR length,
//               the beat count, the following burst address (mod 2^16) and
//               the beats left afterwards. When AXI_READER_BOUNDARY_4K_EN is
//               defined, bursts are also trimmed at 4 KB page boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_reader_burst_calc
    import axi_reader_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic [15:0] addr,
    input  logic [16:0] remaining,
    output logic [7:0]  arlen,
    output logic [8:0]  beats,
    output logic [15:0] next_addr,
    output logic [16:0] next_remaining
);

    localparam int          BYTES     = DATA_W / 8;
    localparam int          LOG2B     = $clog2(BYTES);
    localparam logic [16:0] MAX_BEATS = 17'(MAX_BURST);

    logic [16:0] w_beats;

`ifdef AXI_READER_BOUNDARY_4K_EN
    // Beats left before the address crosses into the next 4 KB page.
    logic [16:0] w_to_4k;
    assign w_to_4k = (17'(BOUNDARY_4K) - {5'd0, addr[11:0]}) >> LOG2B;
`endif

    // Burst length is the smallest of the applicable limits.
    always_comb begin
        w_beats = (remaining < MAX_BEATS) ? remaining : MAX_BEATS;
`ifdef AXI_READER_BOUNDARY_4K_EN
        if (w_to_4k < w_beats) begin
            w_beats = w_to_4k;
        end
`endif
    end

    assign beats          = w_beats[8:0];
    assign arlen          = 8'(w_beats - 17'd1);
    assign next_addr      = addr + 16'(w_beats << LOG2B);
    assign next_remaining = remaining - w_beats;

endmodule : axi_reader_burst_calc
`default_nettype wire

// File: rtl/axi_reader.sv
`default_nettype none
// ============================================================================
// Module      : axi_reader
// Description : AXI4 read master. Accepts an {address, byte length} request,
//               issues INCR bursts on AR one at a time, forwards R beats as
//               an AXI-Stream with per-byte keep and tlast on the final beat,
//               then returns a sticky 1-bit error status.
//               Optional build macro: AXI_READER_BOUNDARY_4K_EN keeps bursts
//               inside 4 KB pages (handled in axi_reader_burst_calc).
// Revision    : 1.0 - initial release
// ============================================================================
module axi_reader
    import axi_reader_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter int         MAX_BURST = 16,
    parameter logic [3:0] ARID      = 4'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           read_req_data,
    input  logic                  read_req_vld,
    output logic                  read_req_rdy,
    output logic                  read_resp_data,
    output logic                  read_resp_vld,
    input  logic                  read_resp_rdy,
    output logic [3:0]            axi_ar_arid,
    output logic [15:0]           axi_ar_araddr,
    output logic [2:0]            axi_ar_arsize,
    output logic [7:0]            axi_ar_arlen,
    output logic [1:0]            axi_ar_arburst,
    output logic                  axi_ar_arvalid,
    input  logic                  axi_ar_arready,
    input  logic [DATA_W-1:0]     axi_r_rdata,
    input  logic [1:0]            axi_r_rresp,
    input  logic                  axi_r_rlast,
    input  logic                  axi_r_rvalid,
    output logic                  axi_r_rready,
    output logic [DATA_W-1:0]     axi_st_tdata,
    output logic [DATA_W/8-1:0]   axi_st_tkeep,
    output logic                  axi_st_tlast,
    output logic                  axi_st_tvalid,
    input  logic                  axi_st_tready
);

    localparam int BYTES = DATA_W / 8;
    localparam int LOG2B = $clog2(BYTES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [15:0]         addr_q,      addr_d;       // next burst address
    logic [16:0]         rem_q,       rem_d;        // beats not yet requested
    logic [8:0]          burst_cnt_q, burst_cnt_d;  // beats left in this burst
    logic [LOG2B-1:0]    off_q,       off_d;        // first valid byte lane
    logic [LOG2B-1:0]    end_q,       end_d;        // last valid byte lane
    logic                first_q,     first_d;
    logic                err_q,       err_d;
    logic                arvalid_q,   arvalid_d;
    logic [15:0]         araddr_q,    araddr_d;
    logic [7:0]          arlen_q,     arlen_d;
    logic [DATA_W-1:0]   tdata_q,     tdata_d;
    logic [BYTES-1:0]    tkeep_q,     tkeep_d;
    logic                tlast_q,     tlast_d;
    logic                tvalid_q,    tvalid_d;
    logic                resp_vld_q,  resp_vld_d;
    logic                resp_data_q, resp_data_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    read_req_t           w_req;
    logic [LOG2B-1:0]    w_off;
    logic [LOG2B-1:0]    w_end;
    logic [15:0]         w_aligned;
    logic [16:0]         w_total;

    assign w_req     = read_req_t'(read_req_data);
    assign w_off     = w_req.addr[LOG2B-1:0];
    assign w_end     = w_req.len[LOG2B-1:0] + w_off - LOG2B'(1);
    assign w_aligned = {w_req.addr[15:LOG2B], {LOG2B{1'b0}}};
    assign w_total   = ({1'b0, w_req.len} + 17'(w_off) + 17'(BYTES - 1)) >> LOG2B;

    // ------------------------------------------------------------------
    // Burst sizing: the first burst is sized straight from the request so
    // AR can be registered on the accepting edge; later bursts use the
    // stored next address and remaining count.
    // ------------------------------------------------------------------
    logic [15:0]         w_calc_addr;
    logic [16:0]         w_calc_rem;
    logic [7:0]          w_arlen;
    logic [8:0]          w_beats;
    logic [15:0]         w_next_addr;
    logic [16:0]         w_next_rem;

    assign w_calc_addr = (state_q == S_IDLE) ? w_aligned : addr_q;
    assign w_calc_rem  = (state_q == S_IDLE) ? w_total   : rem_q;

    axi_reader_burst_calc #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .addr           (w_calc_addr),
        .remaining      (w_calc_rem),
        .arlen          (w_arlen),
        .beats          (w_beats),
        .next_addr      (w_next_addr),
        .next_remaining (w_next_rem)
    );

    // ------------------------------------------------------------------
    // Beat bookkeeping and keep masks
    // ------------------------------------------------------------------
    logic                w_rready;
    logic                w_r_fire;
    logic                w_burst_last;
    logic                w_final;
    logic [BYTES-1:0]    w_first_mask;
    logic [BYTES-1:0]    w_last_mask;
    logic [BYTES-1:0]    w_keep;

    // The output register may be reloaded when empty or draining this cycle.
    assign w_rready     = (state_q == S_R) && (!tvalid_q || axi_st_tready);
    assign w_r_fire     = axi_r_rvalid && w_rready;
    assign w_burst_last = (burst_cnt_q == 9'd1);
    assign w_final      = w_burst_last && (rem_q == '0);
    assign w_first_mask = {BYTES{1'b1}} << off_q;
    assign w_last_mask  = {BYTES{1'b1}} >> (LOG2B'(BYTES - 1) - end_q);

    // Keep mask for the beat being captured; a single-beat request gets both.
    always_comb begin
        w_keep = {BYTES{1'b1}};
        if (first_q) begin
            w_keep = w_keep & w_first_mask;
        end
        if (w_final) begin
            w_keep = w_keep & w_last_mask;
        end
    end

    // Next-state logic for the controller, AR channel and output stage.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        burst_cnt_d = burst_cnt_q;
        off_d       = off_q;
        end_d       = end_q;
        first_d     = first_q;
        err_d       = err_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tlast_d     = tlast_q;
        tvalid_d    = tvalid_q;
        resp_vld_d  = resp_vld_q;
        resp_data_d = resp_data_q;

        if (tvalid_q && axi_st_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (read_req_vld) begin
                    err_d = 1'b0;
                    if (w_req.len == 16'd0) begin
                        state_d     = S_RESP;
                        resp_vld_d  = 1'b1;
                        resp_data_d = 1'b0;
                    end else begin
                        state_d     = S_AR;
                        arvalid_d   = 1'b1;
                        araddr_d    = w_calc_addr;
                        arlen_d     = w_arlen;
                        burst_cnt_d = w_beats;
                        addr_d      = w_next_addr;
                        rem_d       = w_next_rem;
                        off_d       = w_off;
                        end_d       = w_end;
                        first_d     = 1'b1;
                    end
                end
            end
            S_AR: begin
                if (axi_ar_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (w_r_fire) begin
                    tdata_d     = axi_r_rdata;
                    tkeep_d     = w_keep;
                    tlast_d     = w_final;
                    tvalid_d    = 1'b1;
                    first_d     = 1'b0;
                    burst_cnt_d = burst_cnt_q - 9'd1;
                    // Beats are counted internally; rlast is only checked.
                    if ((axi_r_rresp != AXI_RESP_OKAY) ||
                        (axi_r_rlast != w_burst_last)) begin
                        err_d = 1'b1;
                    end
                    if (w_burst_last) begin
                        if (rem_q != '0) begin
                            state_d     = S_AR;
                            arvalid_d   = 1'b1;
                            araddr_d    = w_calc_addr;
                            arlen_d     = w_arlen;
                            burst_cnt_d = w_beats;
                            addr_d      = w_next_addr;
                            rem_d       = w_next_rem;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (tvalid_q && axi_st_tready && tlast_q) begin
                    state_d     = S_RESP;
                    resp_vld_d  = 1'b1;
                    resp_data_d = err_q;
                end
            end
            S_RESP: begin
                if (read_resp_rdy) begin
                    resp_vld_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            burst_cnt_q <= '0;
            off_q       <= '0;
            end_q       <= '0;
            first_q     <= 1'b0;
            err_q       <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            resp_vld_q  <= 1'b0;
            resp_data_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            burst_cnt_q <= burst_cnt_d;
            off_q       <= off_d;
            end_q       <= end_d;
            first_q     <= first_d;
            err_q       <= err_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
            tvalid_q    <= tvalid_d;
            resp_vld_q  <= resp_vld_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign read_req_rdy   = (state_q == S_IDLE);
    assign read_resp_data = resp_data_q;
    assign read_resp_vld  = resp_vld_q;
    assign axi_ar_arid    = ARID;
    assign axi_ar_araddr  = araddr_q;
    assign axi_ar_arsize  = 3'(LOG2B);
    assign axi_ar_arlen   = arlen_q;
    assign axi_ar_arburst = AXI_BURST_INCR;
    assign axi_ar_arvalid = arvalid_q;
    assign axi_r_rready   = w_rready;
    assign axi_st_tdata   = tdata_q;
    assign axi_st_tkeep   = tkeep_q;
    assign axi_st_tlast   = tlast_q;
    assign axi_st_tvalid  = tvalid_q;

endmodule : axi_reader
`default_nettype wire

// File: tb/tb_axi_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_reader
// Description : Directed self-checking bench for axi_reader. A slave model
//               answers AR/R (rdata = {16'hC0DE, beat address}) and logs
//               every AR and stream beat; each test compares the logs with
//               hand-computed values. Expectations for the 4 KB split follow
//               AXI_READER_BOUNDARY_4K_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] read_req_data = '0;
    logic        read_req_vld = 1'b0;
    logic        read_req_rdy;
    logic        read_resp_data;
    logic        read_resp_vld;
    logic        read_resp_rdy = 1'b0;
    logic [3:0]  axi_ar_arid;
    logic [15:0] axi_ar_araddr;
    logic [2:0]  axi_ar_arsize;
    logic [7:0]  axi_ar_arlen;
    logic [1:0]  axi_ar_arburst;
    logic        axi_ar_arvalid;
    logic        axi_ar_arready = 1'b1;
    logic [31:0] axi_r_rdata = '0;
    logic [1:0]  axi_r_rresp = '0;
    logic        axi_r_rlast = 1'b0;
    logic        axi_r_rvalid = 1'b0;
    logic        axi_r_rready;
    logic [31:0] axi_st_tdata;
    logic [3:0]  axi_st_tkeep;
    logic        axi_st_tlast;
    logic        axi_st_tvalid;
    logic        axi_st_tready = 1'b1;

    axi_reader #(.DATA_W(32), .MAX_BURST(16), .ARID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .read_req_data(read_req_data), .read_req_vld(read_req_vld), .read_req_rdy(read_req_rdy),
        .read_resp_data(read_resp_data), .read_resp_vld(read_resp_vld), .read_resp_rdy(read_resp_rdy),
        .axi_ar_arid(axi_ar_arid), .axi_ar_araddr(axi_ar_araddr), .axi_ar_arsize(axi_ar_arsize),
        .axi_ar_arlen(axi_ar_arlen), .axi_ar_arburst(axi_ar_arburst), .axi_ar_arvalid(axi_ar_arvalid),
        .axi_ar_arready(axi_ar_arready),
        .axi_r_rdata(axi_r_rdata), .axi_r_rresp(axi_r_rresp), .axi_r_rlast(axi_r_rlast),
        .axi_r_rvalid(axi_r_rvalid), .axi_r_rready(axi_r_rready),
        .axi_st_tdata(axi_st_tdata), .axi_st_tkeep(axi_st_tkeep), .axi_st_tlast(axi_st_tlast),
        .axi_st_tvalid(axi_st_tvalid), .axi_st_tready(axi_st_tready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Logs: AR = {id, size, burst, len, addr}; stream = {last, keep, data}
    logic [32:0] ar_log[$];
    logic [36:0] st_log[$];
    logic [15:0] bq_addr[$];
    int          bq_beats[$];
    int          r_beat   = 0;
    int          r_gbeat  = 0;
    int          err_beat = -1;
    bit          tready_mode = 1'b0;
    bit          tog = 1'b1;
    logic [15:0] ba;

    function automatic logic [32:0] ar_e(input logic [7:0] len, input logic [15:0] a);
        return {4'd0, 3'd2, 2'b01, len, a};
    endfunction

    function automatic logic [36:0] st_e(input logic last, input logic [3:0] keep, input logic [15:0] a);
        return {last, keep, 16'hC0DE, a};
    endfunction

    // Slave model: drive on the falling edge, observe handshakes 2 units later.
    initial begin : slave_model
        forever begin
            @(negedge clk);
            if (tready_mode) begin
                axi_st_tready = tog;
                tog = ~tog;
            end else begin
                axi_st_tready = 1'b1;
            end
            if (bq_addr.size() > 0) begin
                ba           = bq_addr[0] + 16'(r_beat * 4);
                axi_r_rvalid = 1'b1;
                axi_r_rdata  = {16'hC0DE, ba};
                axi_r_rlast  = (r_beat == bq_beats[0] - 1);
                axi_r_rresp  = (r_gbeat == err_beat) ? 2'd2 : 2'd0;
            end else begin
                axi_r_rvalid = 1'b0;
                axi_r_rdata  = '0;
                axi_r_rlast  = 1'b0;
                axi_r_rresp  = 2'd0;
            end
            #2;
            if (axi_ar_arvalid && axi_ar_arready) begin
                ar_log.push_back({axi_ar_arid, axi_ar_arsize, axi_ar_arburst, axi_ar_arlen, axi_ar_araddr});
                bq_addr.push_back(axi_ar_araddr);
                bq_beats.push_back(int'(axi_ar_arlen) + 1);
            end
            if (axi_r_rvalid && axi_r_rready) begin
                r_beat++;
                r_gbeat++;
                if (r_beat == bq_beats[0]) begin
                    void'(bq_addr.pop_front());
                    void'(bq_beats.pop_front());
                    r_beat = 0;
                end
            end
            if (axi_st_tvalid && axi_st_tready) begin
                st_log.push_back({axi_st_tlast, axi_st_tkeep, axi_st_tdata});
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        ar_log.delete();
        st_log.delete();
        bq_addr.delete();
        bq_beats.delete();
        r_beat  = 0;
        r_gbeat = 0;
    endtask

    // Issue one request; returns at the sample point where resp_vld is seen.
    task automatic do_request(input logic [15:0] addr, input logic [15:0] len,
                              output int lat, output logic resp, output bit tmo);
        int w;
        tmo  = 1'b0;
        lat  = 0;
        resp = 1'bx;
        @(negedge clk);
        read_req_data = {addr, len};
        read_req_vld  = 1'b1;
        #3;
        w = 0;
        while (!read_req_rdy && w < 100) begin
            @(negedge clk); #3; w++;
        end
        if (!read_req_rdy) tmo = 1'b1;
        @(negedge clk);
        read_req_vld = 1'b0;
        #3;
        lat = 1;
        while (!read_resp_vld && lat < 3000) begin
            @(negedge clk); #3; lat++;
        end
        if (!read_resp_vld) tmo = 1'b1;
        else resp = read_resp_data;
    endtask

    task automatic ack_resp();
        read_resp_rdy = 1'b1;
        @(negedge clk);
        read_resp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); #3;
        n_checks++;
        if (read_req_rdy !== 1'b1) begin n_fails++; $display("FAIL reset_req_rdy: got %b, expected 1", read_req_rdy); end
        n_checks++;
        if ({axi_ar_arvalid, axi_r_rready, axi_st_tvalid, axi_st_tlast, read_resp_vld, read_resp_data} !== 6'b0) begin
            n_fails++; $display("FAIL reset_ctrl: got %b, expected 000000", {axi_ar_arvalid, axi_r_rready, axi_st_tvalid, axi_st_tlast, read_resp_vld, read_resp_data});
        end
        n_checks++;
        if ({axi_st_tdata, axi_st_tkeep} !== 36'h0) begin n_fails++; $display("FAIL reset_data: got %h, expected 0", {axi_st_tdata, axi_st_tkeep}); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_burst();
        int lat; logic resp; bit tmo;
        logic [36:0] exp_st[4];
        clear_logs();
        do_request(16'h0000, 16'd16, lat, resp, tmo);
        n_checks++;
        if (tmo || resp !== 1'b0) begin n_fails++; $display("FAIL single_resp: got %b (timeout %0d), expected 0", resp, tmo); end
        ack_resp();
        n_checks++;
        if (ar_log.size() != 1 || ar_log[0] !== ar_e(8'd3, 16'h0000)) begin
            n_fails++; $display("FAIL single_ar: got %0d ARs first %h, expected 1 AR %h", ar_log.size(), (ar_log.size() > 0) ? ar_log[0] : 33'h0, ar_e(8'd3, 16'h0000));
        end
        for (int i = 0; i < 4; i++) exp_st[i] = st_e(i == 3, 4'hF, 16'(4 * i));
        n_checks++;
        if (st_log.size() != 4) begin n_fails++; $display("FAIL single_beats: got %0d, expected 4", st_log.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= st_log.size() || st_log[i] !== exp_st[i]) begin
                n_fails++; $display("FAIL single_beat%0d: got %h, expected %h", i, (i < st_log.size()) ? st_log[i] : 37'h0, exp_st[i]);
            end
        end
    endtask

    task automatic test_unaligned();
        int lat; logic resp; bit tmo;
        logic [36:0] exp_st[3];
        clear_logs();
        do_request(16'h0003, 16'd6, lat, resp, tmo);
        n_checks++;
        if (tmo || resp !== 1'b0) begin n_fails++; $display("FAIL unaligned_resp: got %b (timeout %0d), expected 0", resp, tmo); end
        ack_resp();
        n_checks++;
        if (ar_log.size() != 1 || ar_log[0] !== ar_e(8'd2, 16'h0000)) begin
            n_fails++; $display("FAIL unaligned_ar: got %0d ARs first %h, expected %h", ar_log.size(), (ar_log.size() > 0) ? ar_log[0] : 33'h0, ar_e(8'd2, 16'h0000));
        end
        exp_st[0] = st_e(1'b0, 4'h8, 16'h0000);
        exp_st[1] = st_e(1'b0, 4'hF, 16'h0004);
        exp_st[2] = st_e(1'b1, 4'h1, 16'h0008);
        n_checks++;
        if (st_log.size() != 3) begin n_fails++; $display("FAIL unaligned_beats: got %0d, expected 3", st_log.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= st_log.size() || st_log[i] !== exp_st[i]) begin
                n_fails++; $display("FAIL unaligned_beat%0d: got %h, expected %h", i, (i < st_log.size()) ? st_log[i] : 37'h0, exp_st[i]);
            end
        end
        // Single beat: offset 1, two bytes -> lanes 1..2 only.
        clear_logs();
        do_request(16'h0005, 16'd2, lat, resp, tmo);
        ack_resp();
        n_checks++;
        if (ar_log.size() != 1 || ar_log[0] !== ar_e(8'd0, 16'h0004)) begin
            n_fails++; $display("FAIL onebeat_ar: got %0d ARs first %h, expected %h", ar_log.size(), (ar_log.size() > 0) ? ar_log[0] : 33'h0, ar_e(8'd0, 16'h0004));
        end
        n_checks++;
        if (st_log.size() != 1 || st_log[0] !== st_e(1'b1, 4'h6, 16'h0004)) begin
            n_fails++; $display("FAIL onebeat_beat: got %0d beats first %h, expected %h", st_log.size(), (st_log.size() > 0) ? st_log[0] : 37'h0, st_e(1'b1, 4'h6, 16'h0004));
        end
    endtask

    task automatic test_multi_burst();
        int lat; logic resp; bit tmo;
        logic [36:0] e;
        clear_logs();
        do_request(16'h0000, 16'd100, lat, resp, tmo);
        n_checks++;
        if (tmo || resp !== 1'b0) begin n_fails++; $display("FAIL multi_resp: got %b (timeout %0d), expected 0", resp, tmo); end
        ack_resp();
        n_checks++;
        if (ar_log.size() != 2 || ar_log[0] !== ar_e(8'd15, 16'h0000) || ar_log[1] !== ar_e(8'd8, 16'h0040)) begin
            n_fails++; $display("FAIL multi_ar: got %0d ARs, expected (0000,15) then (0040,8)", ar_log.size());
        end
        n_checks++;
        if (st_log.size() != 25) begin n_fails++; $display("FAIL multi_beats: got %0d, expected 25", st_log.size()); end
        for (int i = 0; i < 25; i++) begin
            e = st_e(i == 24, 4'hF, 16'(4 * i));
            n_checks++;
            if (i >= st_log.size() || st_log[i] !== e) begin
                n_fails++; $display("FAIL multi_beat%0d: got %h, expected %h", i, (i < st_log.size()) ? st_log[i] : 37'h0, e);
            end
        end
    endtask

    task automatic test_boundary();
        int lat; logic resp; bit tmo;
        logic [36:0] e;
        clear_logs();
        do_request(16'h0FF0, 16'd32, lat, resp, tmo);
        n_checks++;
        if (tmo || resp !== 1'b0) begin n_fails++; $display("FAIL boundary_resp: got %b (timeout %0d), expected 0", resp, tmo); end
        ack_resp();
`ifdef AXI_READER_BOUNDARY_4K_EN
        n_checks++;
        if (ar_log.size() != 2 || ar_log[0] !== ar_e(8'd3, 16'h0FF0) || ar_log[1] !== ar_e(8'd3, 16'h1000)) begin
            n_fails++; $display("FAIL boundary_ar: got %0d ARs, expected (0FF0,3) then (1000,3)", ar_log.size());
        end
`else
        n_checks++;
        if (ar_log.size() != 1 || ar_log[0] !== ar_e(8'd7, 16'h0FF0)) begin
            n_fails++; $display("FAIL boundary_ar: got %0d ARs first %h, expected %h", ar_log.size(), (ar_log.size() > 0) ? ar_log[0] : 33'h0, ar_e(8'd7, 16'h0FF0));
        end
`endif
        for (int i = 0; i < 8; i++) begin
            e = st_e(i == 7, 4'hF, 16'h0FF0 + 16'(4 * i));
            n_checks++;
            if (i >= st_log.size() || st_log[i] !== e) begin
                n_fails++; $display("FAIL boundary_beat%0d: got %h, expected %h", i, (i < st_log.size()) ? st_log[i] : 37'h0, e);
            end
        end
    endtask

    task automatic test_zero_len();
        int lat; logic resp; bit tmo;
        clear_logs();
        do_request(16'h1234, 16'd0, lat, resp, tmo);
        n_checks++;
        if (tmo || lat != 1) begin n_fails++; $display("FAIL zero_latency: got %0d cycles (timeout %0d), expected 1", lat, tmo); end
        n_checks++;
        if (resp !== 1'b0) begin n_fails++; $display("FAIL zero_resp: got %b, expected 0", resp); end
        repeat (2) @(negedge clk);
        #3;
        n_checks++;
        if (read_resp_vld !== 1'b1) begin n_fails++; $display("FAIL zero_hold: resp_vld got %b, expected 1 while rdy low", read_resp_vld); end
        ack_resp();
        #3;
        n_checks++;
        if (read_resp_vld !== 1'b0 || read_req_rdy !== 1'b1) begin
            n_fails++; $display("FAIL zero_release: vld %b rdy %b, expected vld 0 rdy 1", read_resp_vld, read_req_rdy);
        end
        n_checks++;
        if (ar_log.size() != 0 || st_log.size() != 0) begin
            n_fails++; $display("FAIL zero_traffic: got %0d ARs %0d beats, expected none", ar_log.size(), st_log.size());
        end
    endtask

    task automatic test_error_backpressure();
        int lat; logic resp; bit tmo;
        logic [36:0] e;
        clear_logs();
        err_beat    = 1;
        tog         = 1'b1;
        tready_mode = 1'b1;
        do_request(16'h0200, 16'd16, lat, resp, tmo);
        n_checks++;
        if (tmo || resp !== 1'b1) begin n_fails++; $display("FAIL error_resp: got %b (timeout %0d), expected 1", resp, tmo); end
        ack_resp();
        err_beat    = -1;
        tready_mode = 1'b0;
        n_checks++;
        if (st_log.size() != 4) begin n_fails++; $display("FAIL error_beats: got %0d, expected 4", st_log.size()); end
        for (int i = 0; i < 4; i++) begin
            e = st_e(i == 3, 4'hF, 16'h0200 + 16'(4 * i));
            n_checks++;
            if (i >= st_log.size() || st_log[i] !== e) begin
                n_fails++; $display("FAIL error_beat%0d: got %h, expected %h", i, (i < st_log.size()) ? st_log[i] : 37'h0, e);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int lat; logic resp; bit tmo;
        clear_logs();
        @(negedge clk);
        read_req_data = {16'h0000, 16'd64};
        read_req_vld  = 1'b1;
        @(negedge clk);
        read_req_vld  = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (st_log.size() == 0) begin n_fails++; $display("FAIL midrst_progress: got 0 beats before reset, expected some"); end
        clear_logs();
        #2;
        n_checks++;
        if ({axi_ar_arvalid, axi_r_rready, axi_st_tvalid, axi_st_tlast, read_resp_vld, read_resp_data} !== 6'b0 ||
            {axi_st_tdata, axi_st_tkeep, axi_ar_araddr, axi_ar_arlen} !== 60'h0) begin
            n_fails++; $display("FAIL midrst_outputs: ctrl %b data %h keep %h araddr %h arlen %h, expected all 0",
                {axi_ar_arvalid, axi_r_rready, axi_st_tvalid, axi_st_tlast, read_resp_vld, read_resp_data},
                axi_st_tdata, axi_st_tkeep, axi_ar_araddr, axi_ar_arlen);
        end
        n_checks++;
        if (read_req_rdy !== 1'b1) begin n_fails++; $display("FAIL midrst_req_rdy: got %b, expected 1", read_req_rdy); end
        @(negedge clk);
        rst = 1'b1;
        clear_logs();
        do_request(16'h0100, 16'd8, lat, resp, tmo);
        n_checks++;
        if (tmo || resp !== 1'b0) begin n_fails++; $display("FAIL after_rst_resp: got %b (timeout %0d), expected 0", resp, tmo); end
        ack_resp();
        n_checks++;
        if (ar_log.size() != 1 || ar_log[0] !== ar_e(8'd1, 16'h0100)) begin
            n_fails++; $display("FAIL after_rst_ar: got %0d ARs first %h, expected %h", ar_log.size(), (ar_log.size() > 0) ? ar_log[0] : 33'h0, ar_e(8'd1, 16'h0100));
        end
        n_checks++;
        if (st_log.size() != 2 || st_log[0] !== st_e(1'b0, 4'hF, 16'h0100) || st_log[1] !== st_e(1'b1, 4'hF, 16'h0104)) begin
            n_fails++; $display("FAIL after_rst_beats: got %0d beats, expected 2 (0100 then 0104 last)", st_log.size());
        end
    endtask

    initial begin : main
        test_reset();
        test_single_burst();
        test_unaligned();
        test_multi_burst();
        test_boundary();
        test_zero_len();
        test_error_backpressure();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_axi_reader
`default_nettype wire

// File: doc/axi_reader.md
Name: axi_reader

Overview:
Hand-written AXI4 read master, the read-side counterpart of the zstd memory writer. It accepts a {address, byte length} request, splits it into INCR bursts on AR, and collects R beats. It forwards the data as an AXI-Stream with per-byte keep masks and tlast on the final beat, then returns a 1-bit status once the stream has drained.

Parameters:
DATA_W, 32, AXI R and stream data width in bits; power of two, at least 16; BYTES = DATA_W/8.
MAX_BURST, 16, maximum beats per AR burst (1..256).
ARID, 0, constant value driven on axi_ar_arid.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-low reset.
read_req_data  in  32  {address[31:16], length_bytes[15:0]}.
read_req_vld  in  1  request valid.
read_req_rdy  out  1  high only in IDLE.
read_resp_data  out  1  0=OKAY, 1=error.
read_resp_vld  out  1  response valid.
read_resp_rdy  in  1  response ready.
axi_ar_arid  out  4  = ARID.
axi_ar_araddr  out  16  burst start address, BYTES-aligned.
axi_ar_arsize  out  3  log2(BYTES).
axi_ar_arlen  out  8  beats-1.
axi_ar_arburst  out  2  constant 2'b01 (INCR).
axi_ar_arvalid  out  1  AR valid.
axi_ar_arready  in  1  AR ready.
axi_r_rdata  in  DATA_W  read data.
axi_r_rresp  in  2  read response.
axi_r_rlast  in  1  last beat of the burst.
axi_r_rvalid  in  1  R valid.
axi_r_rready  out  1  R ready.
axi_st_tdata  out  DATA_W  raw bus word, not realigned.
axi_st_tkeep  out  BYTES  valid-byte mask.
axi_st_tlast  out  1  final beat of the whole request.
axi_st_tvalid  out  1  stream valid.
axi_st_tready  in  1  stream ready.

Behaviour:
- Reset (rst=0, async): state=IDLE. All vld/valid/ready outputs are 0 except read_req_rdy=1 once in IDLE. Data outputs are 0 and the error flag is cleared. Reset mid-burst abandons the transfer; no drain of outstanding R beats.
- States: IDLE -> (req accepted, len!=0) AR -> (arvalid&&arready) R -> (last beat of burst accepted) AR if beats remain, else DRAIN -> (final stream beat accepted) RESP -> (resp_rdy) IDLE. A request with len=0 goes IDLE -> RESP with data=0 and issues no AR.
- Beat counts: off = addr%BYTES. Total beats = ceil((off+len)/BYTES), computed in 17 bits. The first araddr is addr with the low bits cleared. Burst beats = min(remaining, MAX_BURST, beats to the next 4 KB boundary when enabled). Address advances by beats*BYTES and wraps mod 2^16.
- Only one outstanding burst at a time; arvalid is held stable until arready.
- Output stage is a single register with 1-cycle latency from R handshake to tvalid. rready = (state==R) && (!tvalid || tready).
- tkeep: first beat sets bits >= off. Last beat sets bits <= (off+len-1)%BYTES. A single-beat request applies both masks. All other beats are all-ones.
- Error flag is sticky per request. It is set on rresp!=0, on rlast=1 before the counted last beat, or on rlast=0 at the counted last beat. Beats are always counted by the internal counter, never by rlast. read_resp_data = flag.
- read_resp_vld is held until read_resp_rdy.

Optional Feature:
AXI_READER_BOUNDARY_4K_EN: when defined, bursts are additionally split so that none crosses a 4 KB address boundary. When undefined, only MAX_BURST limits the burst length.

Decomposition:
axi_reader_pkg: state enum, AXI_RESP_OKAY, AXI_BURST_INCR, 4 KB constant, the {addr,len} request struct.
Sub-module axi_reader_burst_calc (combinational): takes {addr, remaining beats} and produces {arlen, next addr, next remaining}.

Test Plan:
- addr 0x0000, len 16 -> one AR with araddr 0, arlen 3, arsize 2; 4 beats with tkeep F,F,F,F; tlast on beat 4; resp 0.
- addr 0x0003, len 6 -> AR araddr 0x0000, arlen 2; tkeep 8,F,1; tlast on beat 3.
- addr 0x0000, len 100 -> ARs (0x0000, arlen 15) then (0x0040, arlen 8); 25 beats; tlast only on beat 25.
- addr 0x0FF0, len 32 with _EN -> ARs (0x0FF0, arlen 3) and (0x1000, arlen 3); without _EN -> one AR with arlen 7.
- len 0 -> no AR; resp_vld with data 0 in the cycle after acceptance.
- rresp=2 on beat 2 of 4, tready toggling 1010 -> all 4 beats delivered in order, resp 1. Then assert rst mid-burst -> all outputs 0 and the next request completes cleanly.
